// File: rtl/branch_cmd_issuer_if.sv
// Command and issue bundle between the sequencer, the branch command issuer and
// the branch control block.
interface branch_cmd_issuer_if #(
   parameter int unsigned LANES = 16,
   parameter int unsigned DW    = 3
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [LANES-1:0]      cmd_branch;
   logic [LANES-1:0]      cmd_merge;
   logic [LANES-1:0]      cmd_pred;
   logic [LANES-1:0]      branch_set;
   logic [LANES-1:0]      merge_set;
   logic [LANES-1:0]      branch_in;
   logic [LANES*DW-1:0]   depth;
   logic [LANES-1:0]      overflow_err;
   logic [LANES-1:0]      underflow_err;
   logic                  err_clr;

   modport master (
      output cmd_valid, cmd_branch, cmd_merge, cmd_pred, err_clr,
      input  cmd_ready, branch_set, merge_set, branch_in, depth, overflow_err, underflow_err
   );

   modport slave (
      input  cmd_valid, cmd_branch, cmd_merge, cmd_pred, err_clr,
      output cmd_ready, branch_set, merge_set, branch_in, depth, overflow_err, underflow_err
   );
endinterface

// File: rtl/branch_cmd_issuer.sv
// Turns per-lane branch/merge commands into one-cycle push/pop pulses, tracking lane
// depth so the downstream branch stacks never overflow or underflow.
module branch_cmd_issuer #(
   parameter int unsigned LANES = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 3
) (
   input logic                clk,
   input logic                rst,
   input logic                en,
   branch_cmd_issuer_if.slave bus
);
   typedef enum logic [0:0] {StIdle, StSplit} state_e;

   localparam logic [DW-1:0] Full = DW'(DEPTH);

   state_e              state_q;
   logic [LANES-1:0]    bs_q, ms_q, bi_q;
   logic [LANES-1:0]    pend_q, pend_pred_q;
   logic [LANES-1:0]    ovf_q, unf_q;
   logic [LANES*DW-1:0] depth_q, depth_d;
   logic [LANES-1:0]    m_ok, b_ok, conf, ovf_hit, unf_hit;
   logic                accept;

   always_comb begin
      accept  = (state_q == StIdle) && en && bus.cmd_valid;
      depth_d = depth_q;
      m_ok    = '0;
      b_ok    = '0;
      ovf_hit = '0;
      unf_hit = '0;
      for (int i = 0; i < LANES; i++) begin
         m_ok[i]    = bus.cmd_merge[i] && (depth_q[i*DW +: DW] != '0);
         b_ok[i]    = bus.cmd_branch[i] && (depth_q[i*DW +: DW] < Full);
         ovf_hit[i] = accept && bus.cmd_branch[i] && (depth_q[i*DW +: DW] == Full);
         unf_hit[i] = accept && bus.cmd_merge[i] && (depth_q[i*DW +: DW] == '0);
         // A conflicting lane pops now and pushes in the split cycle.
         if (accept && m_ok[i]) begin
            depth_d[i*DW +: DW] = depth_q[i*DW +: DW] - DW'(1);
         end else if (accept && b_ok[i]) begin
            depth_d[i*DW +: DW] = depth_q[i*DW +: DW] + DW'(1);
         end else if ((state_q == StSplit) && en && pend_q[i]) begin
            depth_d[i*DW +: DW] = depth_q[i*DW +: DW] + DW'(1);
         end
      end
      conf = m_ok & b_ok;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         bs_q        <= '0;
         ms_q        <= '0;
         bi_q        <= '0;
         pend_q      <= '0;
         pend_pred_q <= '0;
         ovf_q       <= '0;
         unf_q       <= '0;
         depth_q     <= '0;
      end else begin
         depth_q <= depth_d;
         // A new error in the clearing cycle keeps its bit set.
         ovf_q   <= (bus.err_clr ? '0 : ovf_q) | ovf_hit;
         unf_q   <= (bus.err_clr ? '0 : unf_q) | unf_hit;
         bs_q    <= '0;
         ms_q    <= '0;
         bi_q    <= '0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  ms_q <= m_ok;
                  bs_q <= b_ok & ~m_ok;
                  bi_q <= bus.cmd_pred & b_ok & ~m_ok;
                  if (|conf) begin
                     pend_q      <= conf;
                     pend_pred_q <= bus.cmd_pred & conf;
                     state_q     <= StSplit;
                  end
               end
            end
            StSplit: begin
               if (en) begin
                  bs_q    <= pend_q;
                  bi_q    <= pend_pred_q;
                  pend_q  <= '0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.cmd_ready     = rst && en && (state_q == StIdle);
   assign bus.branch_set    = bs_q;
   assign bus.merge_set     = ms_q;
   assign bus.branch_in     = bi_q;
   assign bus.depth         = depth_q;
   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_branch_cmd_issuer.sv
// Randomised bench for branch_cmd_issuer against a per-lane behavioural model,
// preceded by directed cases with literal expectations.
module tb_branch_cmd_issuer;
   localparam int LANES = 16;
   localparam int DEPTH = 4;
   localparam int DW    = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;

   always #5 clk = ~clk;

   branch_cmd_issuer_if #(.LANES(LANES), .DW(DW)) bus ();

   branch_cmd_issuer #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk),
      .rst(rst),
      .en (en),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   // Model state: lane depths as integers, expected pulses, pending split pushes.
   int               mdepth[LANES];
   logic [LANES-1:0] mov, mun, ebs, ems, ebi, mpend, mpred;
   bit               msplit;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [LANES*DW-1:0] mdepth_vec();
      logic [LANES*DW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'(mdepth[i]);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LANES; i++) mdepth[i] = 0;
      mov = '0; mun = '0; ebs = '0; ems = '0; ebi = '0;
      mpend = '0; mpred = '0; msplit = 1'b0;
   endtask

   task automatic model_update();
      logic [LANES-1:0] nov, nun, nbs, nms, nbi, npend, npred;
      if (!rst) begin
         model_reset();
         return;
      end
      nov = '0; nun = '0; nbs = '0; nms = '0; nbi = '0; npend = '0; npred = '0;
      if (msplit) begin
         if (en) begin
            nbs = mpend;
            nbi = mpred;
            for (int i = 0; i < LANES; i++) if (mpend[i]) mdepth[i]++;
            msplit = 1'b0;
            mpend  = '0;
         end
      end else if (en && bus.cmd_valid) begin
         for (int i = 0; i < LANES; i++) begin
            int d;
            bit pop, push;
            d    = mdepth[i];
            pop  = bus.cmd_merge[i] && d > 0;
            push = bus.cmd_branch[i] && d < DEPTH;
            if (bus.cmd_merge[i] && d == 0) nun[i] = 1'b1;
            if (bus.cmd_branch[i] && d == DEPTH) nov[i] = 1'b1;
            if (pop) begin
               nms[i] = 1'b1;
               mdepth[i]--;
            end
            if (push && pop) begin
               npend[i] = 1'b1;
               npred[i] = bus.cmd_pred[i];
            end else if (push) begin
               nbs[i] = 1'b1;
               nbi[i] = bus.cmd_pred[i];
               mdepth[i]++;
            end
         end
         if (npend != '0) begin
            msplit = 1'b1;
            mpend  = npend;
            mpred  = npred;
         end
      end
      mov = (bus.err_clr ? '0 : mov) | nov;
      mun = (bus.err_clr ? '0 : mun) | nun;
      ebs = nbs;
      ems = nms;
      ebi = nbi;
   endtask

   task automatic check_model();
      chk("branch_set", 64'(bus.branch_set), 64'(ebs));
      chk("merge_set", 64'(bus.merge_set), 64'(ems));
      chk("branch_in", 64'(bus.branch_in), 64'(ebi));
      chk("depth", 64'(bus.depth), 64'(mdepth_vec()));
      chk("overflow_err", 64'(bus.overflow_err), 64'(mov));
      chk("underflow_err", 64'(bus.underflow_err), 64'(mun));
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(rst && en && !msplit));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_model();
   endtask

   task automatic drive(input logic v, input logic [LANES-1:0] b, input logic [LANES-1:0] m,
                        input logic [LANES-1:0] p, input logic c);
      bus.cmd_valid  = v;
      bus.cmd_branch = b;
      bus.cmd_merge  = m;
      bus.cmd_pred   = p;
      bus.err_clr    = c;
   endtask

   initial begin
      int cnt;
      drive(1'b0, '0, '0, '0, 1'b0);
      model_reset();
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_ready", 64'(bus.cmd_ready), 64'h0);
      chk("reset_bs", 64'(bus.branch_set), 64'h0);
      chk("reset_depth", 64'(bus.depth), 64'h0);
      rst = 1'b1;

      // Single branch on lane 0.
      drive(1'b1, 16'h0001, 16'h0000, 16'h0001, 1'b0);
      step();
      chk("tp1_bs", 64'(bus.branch_set), 64'h0001);
      chk("tp1_bi", 64'(bus.branch_in), 64'h0001);
      chk("tp1_depth0", 64'(bus.depth[0 +: DW]), 64'd1);
      chk("tp1_ready", 64'(bus.cmd_ready), 64'h1);

      // Overflow on lane 3.
      drive(1'b1, 16'h0008, 16'h0000, 16'h0000, 1'b0);
      cnt = 0;
      repeat (5) begin
         step();
         if (bus.branch_set[3]) cnt++;
      end
      chk("ovf_pulses", 64'(cnt), 64'd4);
      chk("ovf_depth3", 64'(bus.depth[3*DW +: DW]), 64'd4);
      chk("ovf_err", 64'(bus.overflow_err), 64'h0008);
      drive(1'b0, '0, '0, '0, 1'b1);
      step();
      chk("ovf_clr", 64'(bus.overflow_err), 64'h0000);

      // Underflow on lane 5.
      drive(1'b1, 16'h0000, 16'h0020, 16'h0000, 1'b0);
      step();
      chk("unf_ms", 64'(bus.merge_set), 64'h0000);
      chk("unf_err", 64'(bus.underflow_err), 64'h0020);
      chk("unf_depth5", 64'(bus.depth[5*DW +: DW]), 64'd0);

      // Pop-then-push split on lane 2.
      drive(1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0);
      step();
      drive(1'b1, 16'h0006, 16'h0004, 16'h0004, 1'b0);
      step();
      chk("split1_ms", 64'(bus.merge_set), 64'h0004);
      chk("split1_bs", 64'(bus.branch_set), 64'h0002);
      chk("split1_ready", 64'(bus.cmd_ready), 64'h0);
      drive(1'b0, '0, '0, '0, 1'b0);
      step();
      chk("split2_bs", 64'(bus.branch_set), 64'h0004);
      chk("split2_bi", 64'(bus.branch_in), 64'h0004);
      chk("split_depth2", 64'(bus.depth[2*DW +: DW]), 64'd1);
      chk("split_depth1", 64'(bus.depth[1*DW +: DW]), 64'd1);
      chk("model_depth2", 64'(mdepth[2]), 64'd1);

      // Stall.
      drive(1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0);
      en = 1'b0;
      #1;
      chk("stall_ready", 64'(bus.cmd_ready), 64'h0);
      step();
      chk("stall_bs", 64'(bus.branch_set), 64'h0000);
      chk("stall_depth0", 64'(bus.depth[0 +: DW]), 64'd1);
      en = 1'b1;
      step();
      chk("resume_bs", 64'(bus.branch_set), 64'h0001);
      chk("resume_depth0", 64'(bus.depth[0 +: DW]), 64'd2);

      // Asynchronous reset while a split push is pending.
      drive(1'b1, 16'h0001, 16'h0001, 16'h0001, 1'b0);
      step();
      chk("rsplit_ready", 64'(bus.cmd_ready), 64'h0);
      drive(1'b0, '0, '0, '0, 1'b0);
      rst = 1'b0;
      #1;
      model_reset();
      chk("arst_depth", 64'(bus.depth), 64'h0);
      chk("arst_ms", 64'(bus.merge_set), 64'h0);
      chk("arst_unf", 64'(bus.underflow_err), 64'h0);
      chk("arst_ready", 64'(bus.cmd_ready), 64'h0);
      step();
      rst = 1'b1;
      step();
      chk("arst_nopend", 64'(bus.branch_set), 64'h0);

      // Random traffic.
      repeat (3000) begin
         drive(1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom & $urandom),
               16'($urandom), 1'($urandom_range(19) == 0));
         en  = 1'($urandom_range(9) != 0);
         rst = 1'($urandom_range(199) != 0);
         if (!rst) model_reset();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
